mpi_recv_responder: RTL and testbench
=====================================

# mpi_recv_responder

Hardware receive end of the MPI rendezvous protocol that the sender side initiates over the 64-bit network stream. It accepts a receive request from the application, then:
- waits for the matching synchronous envelope,
- answers with clear-to-send,
- forwards the data packet payload to the application stream,
- closes the transfer with a data-transmission-done packet.

It sits between the Ethernet decapsulation/encapsulation block (which strips and adds MAC framing) and the application kernel.

## Interface
Parameters:
- CTS_DELAY, 10: idle cycles between envelope acceptance and clear-to-send launch.
- TIMEOUT_CYCLES, 4096: wait limit in WAIT_ENV / WAIT_DATA, used only with the timeout macro.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- local_rank  in  16  this node's rank.
- recv_req  in  1  one-cycle pulse; starts a receive. Ignored unless idle.
- recv_src_rank  in  8  expected sender rank; sampled on recv_req.
- recv_size  in  16  receive buffer capacity in 32-bit words; sampled on recv_req.
- recv_busy  out  1  high from accepted recv_req until return to IDLE.
- recv_done  out  1  one-cycle pulse when the done packet is accepted downstream.
- recv_error  out  3  sticky until next recv_req. Bit0 size overflow; bit1 length mismatch; bit2 timeout.
- net_in_data/keep/last/valid/ready  in/in/in/in/out  64/8/1/1/1  network receive stream.
- net_out_data/keep/last/valid/ready  out/out/out/out/in  64/8/1/1/1  network reply stream.
- app_out_data/keep/last/valid/ready  out/out/out/out/in  64/8/1/1/1  payload to application.

## Operation
Header word fields:
- [15:0] dst_rank
- [23:16] src_rank
- [31:24] packet_type
- [47:32] size
- [55:48] tag
- [63:56] = 8'h01

Packet type codes:
- SYNC_ENV = 0
- CLR2SND = 1
- DATA = 2
- ASYNC_ENV = 3
- RECV_ERROR = 4
- DONE = 5

The header is always the first beat of a packet. A packet "matches" when:
- packet_type equals the state's expected type,
- src_rank equals the latched src, and
- dst_rank equals local_rank.

Non-matching packets are consumed and dropped through their last beat (net_in_ready=1).

States:
- IDLE: net_in_ready=1 and all input is dropped. On recv_req: latch src/size, clear recv_error, go to WAIT_ENV.
- WAIT_ENV: match SYNC_ENV.
  - Envelope size ≤ recv_size: go to DRAIN_ENV.
  - Envelope size > recv_size: set error bit0 and go to DRAIN_ERR.
- DRAIN_ENV / DRAIN_ERR: consume beats to last. Then go to DELAY, or to SEND_ERR for DRAIN_ERR.
- DELAY: count CTS_DELAY cycles, then go to SEND_CTS.
- SEND_CTS: drive one beat with keep=FF, last=1:
  - type CLR2SND
  - dst=latched src
  - src=local_rank[7:0]
  - size=envelope size
  - tag=0
  
  Hold until net_out_ready, then go to WAIT_DATA.
- WAIT_DATA: match DATA. Latch header size (in bytes), clear the byte counter, go to FWD.
- FWD: pass-through.
  - app_out_* = net_in_*, and net_in_ready = app_out_ready.
  - Byte counter += popcount(keep) per accepted beat.
  - On the last beat: if counter ≠ header size, set bit1. Go to SEND_DONE in all cases.
- SEND_DONE: one beat, type DONE, dst=latched src, src=local_rank[7:0], size=0. On acceptance: pulse recv_done, go to IDLE.
- SEND_ERR: one beat, type RECV_ERROR, same addressing. On acceptance go to IDLE; no recv_done pulse.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Exception: net_in_ready=1 in IDLE after reset.
- recv_busy rises the cycle after recv_req.
- Header match is evaluated in the same cycle as the header beat. Payload is first forwarded on the next beat.
- FWD adds zero latency; app_out back-pressure propagates combinationally to net_in_ready.
- The CTS beat presents at cycle (last envelope beat accepted) + CTS_DELAY + 1.
- Reply beats hold data stable while valid && !ready. valid never drops before acceptance.
- recv_req while busy: ignored.
- A single-beat data packet (header beat with last=1) goes to SEND_DONE with counter 0.
- Byte counter is 17 bits. It saturates at 0x1FFFF, and saturation sets bit1.
- aresetn assertion mid-transfer: immediate return to IDLE. Any partial output packet is abandoned.

## Configuration
- MPI_RECV_TIMEOUT_EN defined: a 32-bit counter runs in WAIT_ENV and WAIT_DATA and reloads on every accepted net_in beat. When it reaches TIMEOUT_CYCLES: set bit2 and go to IDLE without sending any reply.
- MPI_RECV_TIMEOUT_EN undefined: no counter, waits are unbounded, and bit2 is tied 0.

## Test plan
- Nominal transfer, local_rank=1, recv_req with src=2 and size=4:
  - Stimulus: SYNC_ENV header 0x0100_0004_00_02_0001 plus a zero beat.
  - Expect: CTS 0x0100_0004_01_01_0002 eleven cycles later.
  - Stimulus: DATA header with size=16, then 2 full beats, last.
  - Expect: 2 app beats, DONE word 0x0100_0000_05_01_0002, recv_done pulse, recv_error=0.
- Mismatch filtering: an envelope from src=3, then one with dst=7, both dropped with no CTS. A correct envelope then gets a CTS.
- Overflow: envelope size=8 against recv_size=4. Expect a RECV_ERROR beat, recv_error=3'b001, no recv_done.
- Length mismatch: DATA header size=16 with a final keep=0x0F (12 bytes). Expect DONE sent and recv_error=3'b010.
- Back-pressure: app_out_ready toggling every cycle in FWD and net_out_ready low for 5 cycles on CTS. Expect no data loss and a stable CTS word.
- Reset mid-FWD: aresetn low for 2 cycles. Expect all outputs 0 and IDLE. With MPI_RECV_TIMEOUT_EN and TIMEOUT_CYCLES=100, silence after recv_req gives bit2 at cycle 100.

Source files
------------

// File: rtl/mpi_recv_responder.sv
// Receive side of the MPI rendezvous handshake: envelope -> clear-to-send -> payload forward -> done.
// Optional watchdog on the envelope/data waits is enabled by defining MPI_RECV_TIMEOUT_EN.
module mpi_recv_responder #(
   parameter int CTS_DELAY      = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic [15:0] local_rank,
   input  logic        recv_req,
   input  logic [7:0]  recv_src_rank,
   input  logic [15:0] recv_size,
   output logic        recv_busy,
   output logic        recv_done,
   output logic [2:0]  recv_error,
   input  logic [63:0] net_in_data,
   input  logic [7:0]  net_in_keep,
   input  logic        net_in_last,
   input  logic        net_in_valid,
   output logic        net_in_ready,
   output logic [63:0] net_out_data,
   output logic [7:0]  net_out_keep,
   output logic        net_out_last,
   output logic        net_out_valid,
   input  logic        net_out_ready,
   output logic [63:0] app_out_data,
   output logic [7:0]  app_out_keep,
   output logic        app_out_last,
   output logic        app_out_valid,
   input  logic        app_out_ready
);
   localparam logic [7:0] T_SYNC_ENV   = 8'd0;
   localparam logic [7:0] T_CLR2SND    = 8'd1;
   localparam logic [7:0] T_DATA       = 8'd2;
   localparam logic [7:0] T_RECV_ERROR = 8'd4;
   localparam logic [7:0] T_DONE       = 8'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_ENV, S_DRAIN_ENV, S_DRAIN_ERR, S_DELAY,
      S_SEND_CTS, S_WAIT_DATA, S_FWD, S_SEND_DONE, S_SEND_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  src_q, src_d;
   logic [15:0] size_q, size_d;
   logic [15:0] env_size_q, env_size_d;
   logic [15:0] data_size_q, data_size_d;
   logic [16:0] byte_cnt_q, byte_cnt_d;
   logic [31:0] delay_cnt_q, delay_cnt_d;
   logic [2:0]  err_q, err_d;
   logic        sop_q, sop_d;
   logic        tmo_hit;

   logic        in_fire, hdr_fire, addr_ok;
   logic [7:0]  hdr_type;
   logic [15:0] hdr_size;
   logic [3:0]  keep_acc [0:8];
   logic [17:0] byte_sum;
   logic [16:0] byte_new;
   logic [7:0]  reply_type;
   logic [15:0] reply_size;

   assign hdr_type = net_in_data[31:24];
   assign hdr_size = net_in_data[47:32];
   assign addr_ok  = (net_in_data[23:16] == src_q) && (net_in_data[15:0] == local_rank);
   assign in_fire  = net_in_valid && net_in_ready;
   // sop_q tracks packet boundaries so payload words are never mistaken for headers
   assign hdr_fire = in_fire && sop_q;

   assign keep_acc[0] = 4'd0;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pop
      assign keep_acc[gi+1] = keep_acc[gi] + {3'b000, net_in_keep[gi]};
   end
   assign byte_sum = {1'b0, byte_cnt_q} + {14'd0, keep_acc[8]};
   assign byte_new = byte_sum[17] ? 17'h1FFFF : byte_sum[16:0];

`ifdef MPI_RECV_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        tmo_run;
   assign tmo_run = (state_q == S_WAIT_ENV) || (state_q == S_WAIT_DATA);
   assign tmo_d   = (!tmo_run || in_fire) ? 32'd0 : tmo_q + 32'd1;
   assign tmo_hit = tmo_run && !in_fire && (tmo_q + 32'd1 == 32'(TIMEOUT_CYCLES));
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = 32'(TIMEOUT_CYCLES);
   assign tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         size_q      <= '0;
         env_size_q  <= '0;
         data_size_q <= '0;
         byte_cnt_q  <= '0;
         delay_cnt_q <= '0;
         err_q       <= '0;
         sop_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         size_q      <= size_d;
         env_size_q  <= env_size_d;
         data_size_q <= data_size_d;
         byte_cnt_q  <= byte_cnt_d;
         delay_cnt_q <= delay_cnt_d;
         err_q       <= err_d;
         sop_q       <= sop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      size_d      = size_q;
      env_size_d  = env_size_q;
      data_size_d = data_size_q;
      byte_cnt_d  = byte_cnt_q;
      delay_cnt_d = '0;
      err_d       = err_q;
      sop_d       = in_fire ? net_in_last : sop_q;
      case (state_q)
         S_IDLE: if (recv_req) begin
            src_d   = recv_src_rank;
            size_d  = recv_size;
            err_d   = '0;
            state_d = S_WAIT_ENV;
         end
         S_WAIT_ENV: if (hdr_fire && hdr_type == T_SYNC_ENV && addr_ok) begin
            env_size_d = hdr_size;
            if (hdr_size > size_q) begin
               err_d[0] = 1'b1;
               state_d  = net_in_last ? S_SEND_ERR : S_DRAIN_ERR;
            end else begin
               state_d  = net_in_last ? S_DELAY : S_DRAIN_ENV;
            end
         end
         S_DRAIN_ENV: if (in_fire && net_in_last) state_d = S_DELAY;
         S_DRAIN_ERR: if (in_fire && net_in_last) state_d = S_SEND_ERR;
         S_DELAY: begin
            if (delay_cnt_q + 32'd1 >= 32'(CTS_DELAY)) state_d = S_SEND_CTS;
            else delay_cnt_d = delay_cnt_q + 32'd1;
         end
         S_SEND_CTS: if (net_out_ready) state_d = S_WAIT_DATA;
         S_WAIT_DATA: if (hdr_fire && hdr_type == T_DATA && addr_ok) begin
            data_size_d = hdr_size;
            byte_cnt_d  = '0;
            if (net_in_last) begin
               // header-only packet carries zero payload bytes
               if (hdr_size != 16'd0) err_d[1] = 1'b1;
               state_d = S_SEND_DONE;
            end else begin
               state_d = S_FWD;
            end
         end
         S_FWD: if (in_fire) begin
            byte_cnt_d = byte_new;
            if (byte_sum[17]) err_d[1] = 1'b1;
            if (net_in_last) begin
               if (byte_new != {1'b0, data_size_q}) err_d[1] = 1'b1;
               state_d = S_SEND_DONE;
            end
         end
         S_SEND_DONE: if (net_out_ready) state_d = S_IDLE;
         S_SEND_ERR:  if (net_out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (tmo_hit) begin
         err_d[2] = 1'b1;
         state_d  = S_IDLE;
      end
   end

   always_comb begin
      reply_type    = T_CLR2SND;
      reply_size    = env_size_q;
      net_out_valid = 1'b0;
      net_out_data  = '0;
      net_out_keep  = '0;
      net_out_last  = 1'b0;
      app_out_data  = '0;
      app_out_keep  = '0;
      app_out_last  = 1'b0;
      app_out_valid = 1'b0;
      net_in_ready  = 1'b0;
      if (state_q == S_SEND_DONE) begin
         reply_type = T_DONE;
         reply_size = '0;
      end else if (state_q == S_SEND_ERR) begin
         reply_type = T_RECV_ERROR;
         reply_size = '0;
      end
      case (state_q)
         S_IDLE, S_WAIT_ENV, S_DRAIN_ENV, S_DRAIN_ERR, S_WAIT_DATA: net_in_ready = 1'b1;
         S_FWD: begin
            app_out_data  = net_in_data;
            app_out_keep  = net_in_keep;
            app_out_last  = net_in_last;
            app_out_valid = net_in_valid;
            net_in_ready  = app_out_ready;
         end
         S_SEND_CTS, S_SEND_DONE, S_SEND_ERR: begin
            net_out_valid = 1'b1;
            net_out_data  = {8'h01, 8'h00, reply_size, reply_type, local_rank[7:0], 8'h00, src_q};
            net_out_keep  = 8'hFF;
            net_out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   assign recv_busy  = (state_q != S_IDLE);
   assign recv_done  = (state_q == S_SEND_DONE) && net_out_ready;
   assign recv_error = err_q;

endmodule

// File: tb/tb_mpi_recv_responder.sv
// Scoreboard bench for mpi_recv_responder: table of transfers plus reset and timeout sequences.
module tb_mpi_recv_responder;
   localparam int          CTS_DELAY  = 10;
   localparam logic [15:0] LOCAL_RANK = 16'd1;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [15:0] local_rank = LOCAL_RANK;
   logic        recv_req = 1'b0;
   logic [7:0]  recv_src_rank = '0;
   logic [15:0] recv_size = '0;
   logic        recv_busy, recv_done;
   logic [2:0]  recv_error;
   logic [63:0] net_in_data = '0;
   logic [7:0]  net_in_keep = '0;
   logic        net_in_last = 1'b0, net_in_valid = 1'b0, net_in_ready;
   logic [63:0] net_out_data;
   logic [7:0]  net_out_keep;
   logic        net_out_last, net_out_valid;
   logic        net_out_ready = 1'b1;
   logic [63:0] app_out_data;
   logic [7:0]  app_out_keep;
   logic        app_out_last, app_out_valid;
   logic        app_out_ready = 1'b1;

   always #5 clk = ~clk;

   mpi_recv_responder #(.CTS_DELAY(CTS_DELAY), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .aresetn(aresetn), .local_rank(local_rank),
      .recv_req(recv_req), .recv_src_rank(recv_src_rank), .recv_size(recv_size),
      .recv_busy(recv_busy), .recv_done(recv_done), .recv_error(recv_error),
      .net_in_data(net_in_data), .net_in_keep(net_in_keep), .net_in_last(net_in_last),
      .net_in_valid(net_in_valid), .net_in_ready(net_in_ready),
      .net_out_data(net_out_data), .net_out_keep(net_out_keep), .net_out_last(net_out_last),
      .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
      .app_out_data(app_out_data), .app_out_keep(app_out_keep), .app_out_last(app_out_last),
      .app_out_valid(app_out_valid), .app_out_ready(app_out_ready)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   typedef struct {
      logic [7:0]  src;
      logic [15:0] rsize;
      logic [15:0] env_size;
      logic [15:0] data_size;
      int          nbeats;
      logic [7:0]  last_keep;
      logic [2:0]  exp_err;
      int          exp_done;
      bit          junk;
      bit          bp;
   } vec_t;

   beat_t exp_net[$];
   beat_t exp_app[$];
   int    total = 0, bad = 0;
   int    cyc = 0, done_cnt = 0, out_cnt = 0, cts_cyc = -1, stall_cnt = 0;
   logic  bp_en = 1'b0, prev_stall = 1'b0, prev_v = 1'b0;
   logic [63:0] prev_word = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] act);
      total++;
      bad++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   function automatic logic [63:0] hdr(input logic [15:0] dst, input logic [7:0] src,
                                       input logic [7:0] typ, input logic [15:0] size);
      return {8'h01, 8'h00, size, typ, src, dst};
   endfunction

   // monitor: pops the scoreboard on every accepted output beat
   always @(negedge clk) begin
      beat_t b;
      if (aresetn) begin
         if (prev_stall) begin
            check("reply_hold_valid", 64'(net_out_valid), 64'(1));
            check("reply_hold_data", net_out_data, prev_word);
         end
         if (net_out_valid && !prev_v && net_out_data[31:24] == 8'h01) cts_cyc = cyc;
         if (net_out_valid) out_cnt++;
         if (net_out_valid && net_out_ready) begin
            if (exp_net.size() == 0) flag("net_out_unexpected", net_out_data);
            else begin
               b = exp_net.pop_front();
               check("net_out_data", net_out_data, b.d);
               check("net_out_keep", 64'(net_out_keep), 64'(b.k));
               check("net_out_last", 64'(net_out_last), 64'(b.l));
            end
         end
         if (app_out_valid && app_out_ready) begin
            if (exp_app.size() == 0) flag("app_out_unexpected", app_out_data);
            else begin
               b = exp_app.pop_front();
               check("app_out_data", app_out_data, b.d);
               check("app_out_keep", 64'(app_out_keep), 64'(b.k));
               check("app_out_last", 64'(app_out_last), 64'(b.l));
            end
         end
         if (recv_done) done_cnt++;
         prev_stall = net_out_valid && !net_out_ready;
         prev_word  = net_out_data;
         prev_v     = net_out_valid;
      end else begin
         prev_stall = 1'b0;
         prev_v     = 1'b0;
      end
   end

   // back-pressure generator: toggles app ready, stalls the CTS beat for 5 cycles
   initial forever begin
      @(posedge clk); #1;
      app_out_ready = bp_en ? ~app_out_ready : 1'b1;
      if (bp_en && net_out_valid && net_out_data[31:24] == 8'h01 && stall_cnt < 5) begin
         net_out_ready = 1'b0;
         stall_cnt++;
      end else begin
         net_out_ready = 1'b1;
      end
   end

   task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l);
      int  n = 0;
      logic acc;
      net_in_data = d; net_in_keep = k; net_in_last = l; net_in_valid = 1'b1;
      forever begin
         @(negedge clk); acc = net_in_ready;
         @(posedge clk); #1;
         if (acc) break;
         if (++n > 200) begin flag("net_in_accept_timeout", d); break; end
      end
      net_in_valid = 1'b0;
   endtask

   task automatic req(input logic [7:0] s, input logic [15:0] sz);
      recv_req = 1'b1; recv_src_rank = s; recv_size = sz;
      @(posedge clk); #1;
      recv_req = 1'b0; recv_src_rank = 8'($urandom); recv_size = 16'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (recv_busy) begin
         @(posedge clk); #1;
         if (++n > 500) begin flag("idle_timeout", 64'(n)); break; end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(recv_busy), 64'(0));
      check({tag, "_done"}, 64'(recv_done), 64'(0));
      check({tag, "_err"}, 64'(recv_error), 64'(0));
      check({tag, "_net_out"}, {net_out_data[62:0], net_out_valid} | 64'(net_out_keep) | 64'(net_out_last), 64'(0));
      check({tag, "_app_out"}, {app_out_data[62:0], app_out_valid} | 64'(app_out_keep) | 64'(app_out_last), 64'(0));
      check({tag, "_net_in_ready"}, 64'(net_in_ready), 64'(1));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          d0, o0, acc_cyc;
      logic [63:0] w;
      logic        l;
      logic [7:0]  k;
      bp_en = v.bp; stall_cnt = 0;
      d0 = done_cnt;
      req(v.src, v.rsize);
      check($sformatf("v%0d_busy", idx), 64'(recv_busy), 64'(1));
      check($sformatf("v%0d_err_clr", idx), 64'(recv_error), 64'(0));
      req(v.src + 8'd1, v.rsize);  // must be ignored while busy
      if (v.junk) begin
         o0 = out_cnt;
         put(hdr(LOCAL_RANK, v.src ^ 8'h01, 8'd0, v.env_size), 8'hFF, 1'b0);
         put(hdr(LOCAL_RANK, v.src, 8'd0, v.env_size), 8'hFF, 1'b1);
         put(hdr(16'd7, v.src, 8'd0, v.env_size), 8'hFF, 1'b1);
         put(hdr(LOCAL_RANK, v.src, 8'd2, v.env_size), 8'hFF, 1'b1);
         repeat (15) @(posedge clk);
         #1;
         check($sformatf("v%0d_junk_no_reply", idx), 64'(out_cnt - o0), 64'(0));
         check($sformatf("v%0d_junk_busy", idx), 64'(recv_busy), 64'(1));
      end
      if (v.env_size > v.rsize) begin
         exp_net.push_back('{hdr({8'h00, v.src}, LOCAL_RANK[7:0], 8'd4, 16'd0), 8'hFF, 1'b1});
         put(hdr(LOCAL_RANK, v.src, 8'd0, v.env_size), 8'hFF, 1'b0);
         put(64'd0, 8'hFF, 1'b1);
      end else begin
         exp_net.push_back('{hdr({8'h00, v.src}, LOCAL_RANK[7:0], 8'd1, v.env_size), 8'hFF, 1'b1});
         exp_net.push_back('{hdr({8'h00, v.src}, LOCAL_RANK[7:0], 8'd5, 16'd0), 8'hFF, 1'b1});
         put(hdr(LOCAL_RANK, v.src, 8'd0, v.env_size), 8'hFF, 1'b0);
         put(64'd0, 8'hFF, 1'b1);
         acc_cyc = cyc;
         put(hdr(LOCAL_RANK, v.src, 8'd2, v.data_size), 8'hFF, v.nbeats == 0);
         check($sformatf("v%0d_cts_latency", idx), 64'(cts_cyc - acc_cyc), 64'(CTS_DELAY));
         for (int i = 0; i < v.nbeats; i++) begin
            w = {$urandom(), $urandom()};
            l = (i == v.nbeats - 1);
            k = l ? v.last_keep : 8'hFF;
            exp_app.push_back('{w, k, l});
            put(w, k, l);
         end
      end
      wait_idle();
      check($sformatf("v%0d_err", idx), 64'(recv_error), 64'(v.exp_err));
      check($sformatf("v%0d_done_pulses", idx), 64'(done_cnt - d0), 64'(v.exp_done));
      check($sformatf("v%0d_net_sb_empty", idx), 64'(exp_net.size()), 64'(0));
      check($sformatf("v%0d_app_sb_empty", idx), 64'(exp_app.size()), 64'(0));
      $display("vec %0d: src=%0d env=%0d data=%0d err=%b done=%0d", idx, v.src, v.env_size,
               v.data_size, recv_error, done_cnt - d0);
      bp_en = 1'b0;
   endtask

   initial begin
      vec_t        vecs[8];
      logic [63:0] w;
      int          c0;
      //           src    rsize   env     dsize  nb lkeep   err     done junk bp
      vecs[0] = '{8'd2, 16'd4,  16'd4,  16'd16, 2, 8'hFF, 3'b000, 1, 1'b0, 1'b0};
      vecs[1] = '{8'd2, 16'd4,  16'd4,  16'd16, 2, 8'hFF, 3'b000, 1, 1'b1, 1'b0};
      vecs[2] = '{8'd2, 16'd4,  16'd8,  16'd0,  0, 8'hFF, 3'b001, 0, 1'b0, 1'b0};
      vecs[3] = '{8'd5, 16'd8,  16'd8,  16'd16, 2, 8'h0F, 3'b010, 1, 1'b0, 1'b0};
      vecs[4] = '{8'd9, 16'd2,  16'd2,  16'd0,  0, 8'hFF, 3'b000, 1, 1'b0, 1'b0};
      vecs[5] = '{8'd3, 16'd100,16'd100,16'd40, 5, 8'hFF, 3'b000, 1, 1'b0, 1'b1};
      vecs[6] = '{8'd4, 16'd16, 16'd16, 16'd8,  2, 8'hFF, 3'b010, 1, 1'b0, 1'b0};
      vecs[7] = '{8'd6, 16'd4,  16'd3,  16'd20, 3, 8'h0F, 3'b000, 1, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk); #1;
      aresetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // reset in the middle of payload forwarding
      req(8'd2, 16'd4);
      exp_net.push_back('{hdr(16'd2, 8'd1, 8'd1, 16'd4), 8'hFF, 1'b1});
      put(hdr(LOCAL_RANK, 8'd2, 8'd0, 16'd4), 8'hFF, 1'b0);
      put(64'd0, 8'hFF, 1'b1);
      put(hdr(LOCAL_RANK, 8'd2, 8'd2, 16'd32), 8'hFF, 1'b0);
      for (int i = 0; i < 2; i++) begin
         w = {$urandom(), $urandom()};
         exp_app.push_back('{w, 8'hFF, 1'b0});
         put(w, 8'hFF, 1'b0);
      end
      check("midfwd_busy", 64'(recv_busy), 64'(1));
      aresetn = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst1");
      @(negedge clk);
      check_reset_outputs("rst2");
      @(posedge clk); #1;
      aresetn = 1'b1;
      check("rst_net_sb_empty", 64'(exp_net.size()), 64'(0));
      check("rst_app_sb_empty", 64'(exp_app.size()), 64'(0));
      $display("reset mid-FWD: busy=%0d err=%b", recv_busy, recv_error);
      run_vec(vecs[0], 8);

`ifdef MPI_RECV_TIMEOUT_EN
      c0 = cyc;
      req(8'd2, 16'd4);
      wait_idle();
      check("tmo_cycles", 64'(cyc - c0), 64'(101));
      check("tmo_err", 64'(recv_error), 64'(3'b100));
      check("tmo_no_reply", 64'(exp_net.size()), 64'(0));
      $display("timeout: idle after %0d cycles err=%b", cyc - c0, recv_error);
`else
      c0 = 0;
`endif

      repeat (3) @(posedge clk);
      check("final_net_sb_empty", 64'(exp_net.size() + c0 * 0), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
